alu_seq: RTL and testbench

- Parametrised, registered successor to the team's combinational ALU.
- Accepts operands and a 3-bit opcode through a valid/ready handshake.
- Single-cycle ops return a registered result after 1 cycle; unsigned MUL runs as an iterative shift-add over WIDTH cycles.
- Result and ONZ flags are held in output registers for consumption by the datapath/controller.

---
 rtl/alu_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_seq.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready input: single-cycle ops plus an iterative unsigned shift-add MUL.
// Optional macro ALU_SAT_EN: ADD/SUB/INC saturate on signed overflow instead of wrapping.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] Y,
  output logic [2:0]       ONZ,
  output logic             out_valid
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_INC  = 3'b101,
    OP_PASS = 3'b110,
    OP_MUL  = 3'b111
  } op_t;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [2:0]         onz_q, onz_d;
  logic               vld_q, vld_d;

  logic [WIDTH-1:0]   sum, diff, incr;
  logic [WIDTH-1:0]   alu_y;
  logic               alu_o;
  logic [2*WIDTH-1:0] acc_step;

  assign sum  = A + B;
  assign diff = A - B;
  assign incr = A + ONE;

  // Single-cycle datapath; MUL results come from the accumulator instead.
  always_comb begin
    alu_y = '0;
    alu_o = 1'b0;
    unique case (op_t'(op))
      OP_ADD: begin
        alu_y = sum;
        alu_o = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (alu_o) alu_y = A[WIDTH-1] ? SMIN : SMAX;
`endif
      end
      OP_SUB: begin
        alu_y = diff;
        alu_o = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
`ifdef ALU_SAT_EN
        if (alu_o) alu_y = A[WIDTH-1] ? SMIN : SMAX;
`endif
      end
      OP_AND:  alu_y = A & B;
      OP_OR:   alu_y = A | B;
      OP_XOR:  alu_y = A ^ B;
      OP_INC: begin
        alu_y = incr;
        alu_o = (A == SMAX);
`ifdef ALU_SAT_EN
        if (alu_o) alu_y = SMAX;
`endif
      end
      OP_PASS: alu_y = A;
      default: alu_y = '0;
    endcase
  end

  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    onz_d    = onz_q;
    vld_d    = 1'b0;
    in_ready = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (op_t'(op) == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = CW'(WIDTH);
            state_d  = S_BUSY;
          end else begin
            y_d   = alu_y;
            onz_d = {alu_o, alu_y[WIDTH-1], alu_y == '0};
            vld_d = 1'b1;
          end
        end
      end
      S_BUSY: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // Last iteration publishes the freshly summed product directly.
        if (cnt_q == CW'(1)) begin
          y_d     = acc_step[WIDTH-1:0];
          onz_d   = {|acc_step[2*WIDTH-1:WIDTH], acc_step[WIDTH-1],
                     acc_step[WIDTH-1:0] == '0};
          vld_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
      onz_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      onz_q    <= onz_d;
      vld_q    <= vld_d;
    end
  end

  assign Y         = y_q;
  assign ONZ       = onz_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected results, a negedge monitor pops and compares.
module tb_alu_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [2:0]   op = '0;
  logic [W-1:0] Y;
  logic [2:0]   ONZ;
  logic         out_valid;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .Y(Y), .ONZ(ONZ), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] y;
    logic [2:0]   onz;
    int           cyc;
  } exp_t;

  exp_t         q[$];
  int           errors = 0;
  int           checks = 0;
  int           busy_lo = -1;
  int           busy_hi = -1;
  logic [W-1:0] last_y = '0;
  logic [2:0]   last_onz = '0;
  bit           mon_en = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endfunction

  // Reference: signed/unsigned arithmetic on plain integers.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] y, output logic [2:0] onz);
    int     ua, ub, sa, sb, s;
    longint p;
    logic   ov;
    int     maxs, mins;
    maxs = (1 << (W-1)) - 1;
    mins = -(1 << (W-1));
    ua = int'(a);
    ub = int'(b);
    sa = (ua > maxs) ? ua - (1 << W) : ua;
    sb = (ub > maxs) ? ub - (1 << W) : ub;
    ov = 1'b0;
    s  = 0;
    case (o)
      3'd0: s = sa + sb;
      3'd1: s = sa - sb;
      3'd2: s = ua & ub;
      3'd3: s = ua | ub;
      3'd4: s = ua ^ ub;
      3'd5: s = sa + 1;
      3'd6: s = ua;
      default: begin
        p  = longint'(ua) * longint'(ub);
        s  = int'(p % (longint'(1) << W));
        ov = (p >> W) != 0;
      end
    endcase
    if (o == 3'd0 || o == 3'd1 || o == 3'd5) begin
      ov = (s > maxs) || (s < mins);
`ifdef ALU_SAT_EN
      if (s > maxs) s = maxs;
      else if (s < mins) s = mins;
`endif
    end
    y   = s[W-1:0];
    onz = {ov, y[W-1], y == '0};
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !(cyc >= busy_lo && cyc <= busy_hi)});
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_out_valid: expected at cycle %0d, now %0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid at cycle %0d: got 1 expected 0", cyc);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("Y", {24'd0, Y}, {24'd0, e.y});
          chk("ONZ", {29'd0, ONZ}, {29'd0, e.onz});
          last_y   = e.y;
          last_onz = e.onz;
        end
      end else begin
        chk("Y_hold", {24'd0, Y}, {24'd0, last_y});
        chk("ONZ_hold", {29'd0, ONZ}, {29'd0, last_onz});
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit use_model, input logic [W-1:0] ey, input logic [2:0] eonz);
    exp_t         e;
    int           n;
    logic [W-1:0] my;
    logic [2:0]   monz;
    op = o; A = a; B = b; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout op=%0d: got in_ready=0 expected 1 within 100 cycles", o);
    end else begin
      if (use_model) begin
        model(o, a, b, my, monz);
        e.y = my; e.onz = monz;
      end else begin
        e.y = ey; e.onz = eonz;
      end
      e.cyc = cyc + ((o == 3'd7) ? W + 1 : 1);
      q.push_back(e);
      if (o == 3'd7) begin
        busy_lo = cyc + 1;
        busy_hi = cyc + W;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    if (busy_hi > cyc) busy_hi = cyc;
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    last_y = '0;
    last_onz = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

`ifdef ALU_SAT_EN
    issue(3'd0, 8'h7F, 8'h01, 1'b0, 8'h7F, 3'b100);
`else
    issue(3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 3'b110);
`endif
    issue(3'd1, 8'h05, 8'h05, 1'b0, 8'h00, 3'b001);
    issue(3'd2, 8'hF0, 8'h0F, 1'b0, 8'h00, 3'b001);
    @(posedge clk); #1;
    issue(3'd7, 8'd13, 8'd11, 1'b0, 8'h8F, 3'b010);
    issue(3'd7, 8'h10, 8'h10, 1'b0, 8'h00, 3'b101);
    issue(3'd0, 8'h03, 8'h04, 1'b0, 8'h07, 3'b000);
`ifdef ALU_SAT_EN
    issue(3'd5, 8'h7F, 8'h00, 1'b0, 8'h7F, 3'b100);
`else
    issue(3'd5, 8'h7F, 8'h00, 1'b0, 8'h80, 3'b110);
`endif
    issue(3'd5, 8'hFF, 8'h00, 1'b0, 8'h00, 3'b001);
    repeat (3) @(posedge clk); #1;

    // MUL aborted by reset in its fourth busy cycle
    issue(3'd7, 8'hC3, 8'h5A, 1'b1, 8'h00, 3'b000);
    repeat (2) @(posedge clk);
    do_reset();
    repeat (W + 4) @(posedge clk); #1;

    for (int i = 0; i < 300; i++) begin
      logic [2:0]   ro;
      logic [W-1:0] ra, rb;
      int           sel;
      sel = $urandom_range(0, 3);
      ra = (sel == 0) ? 8'h7F : (sel == 1) ? 8'h80 : W'($urandom);
      rb = W'($urandom);
      ro = 3'($urandom_range(0, 7));
      issue(ro, ra, rb, 1'b1, '0, '0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_results: got %0d outstanding expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
